// File: rtl/pll_lock_reset_seq_if.sv
// ----------------------------------------------------------------------------
// pll_lock_reset_seq_if
//   Groups the signals of the PLL-lock reset sequencer, apart from clk and
//   rst_n, into one bundle.
//
//   Signals
//     pll_lock      : PLL LOCK indication, asynchronous to clk
//     sw_reset_req  : single-cycle software reset request, synchronous to clk
//     core_rst_n    : active-low reset for the core domain
//     periph_rst_n  : active-low reset for the peripheral domain
//     ready         : high while the sequencer sits in RUN
//     state         : current sequencer state encoding (3 bits)
//     lock_loss_cnt : saturating count of qualified lock losses (8 bits)
//
//   Modports
//     master : stimulus side; drives pll_lock and sw_reset_req
//     slave  : sequencer side; drives the resets, ready, state and count
// ----------------------------------------------------------------------------
interface pll_lock_reset_seq_if;

    logic       pll_lock;
    logic       sw_reset_req;
    logic       core_rst_n;
    logic       periph_rst_n;
    logic       ready;
    logic [2:0] state;
    logic [7:0] lock_loss_cnt;

    modport master (
        output pll_lock,
        output sw_reset_req,
        input  core_rst_n,
        input  periph_rst_n,
        input  ready,
        input  state,
        input  lock_loss_cnt
    );

    modport slave (
        input  pll_lock,
        input  sw_reset_req,
        output core_rst_n,
        output periph_rst_n,
        output ready,
        output state,
        output lock_loss_cnt
    );

endinterface

// File: rtl/pll_lock_reset_seq.sv
// ----------------------------------------------------------------------------
// pll_lock_reset_seq
//   Reset sequencer driven by a PLL LOCK indication. LOCK is synchronized,
//   must stay high for SETTLE_CYCLES before the core reset is released, and
//   the peripheral reset follows STAGGER_CYCLES later. A filtered loss of
//   lock (LOSS_FILTER consecutive low cycles) while the core is up pulls
//   both resets together, passes through a one-cycle LOST state that bumps
//   a saturating loss counter, and restarts the lock wait.
//
//   Parameters
//     SYNC_STAGES    : depth of the pll_lock synchronizer (2..4)
//     SETTLE_CYCLES  : stable-lock cycles before core release (1..65535)
//     STAGGER_CYCLES : cycles from core release to peripheral release (1..255)
//     LOSS_FILTER    : consecutive low cycles that qualify a loss (1..15)
//
//   Ports
//     clk   : single clock, from the PLL output
//     rst_n : asynchronous active-low reset
//     bus   : slave side of pll_lock_reset_seq_if
//               in : pll_lock, sw_reset_req
//               out: core_rst_n, periph_rst_n, ready, state, lock_loss_cnt
//
//   State encoding: WAIT_LOCK=0, SETTLE=1, CORE_UP=2, RUN=3, LOST=4.
// ----------------------------------------------------------------------------
module pll_lock_reset_seq #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned SETTLE_CYCLES  = 1024,
    parameter int unsigned STAGGER_CYCLES = 16,
    parameter int unsigned LOSS_FILTER    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pll_lock_reset_seq_if.slave  bus
);

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        SETTLE    = 3'd1,
        CORE_UP   = 3'd2,
        RUN       = 3'd3,
        LOST      = 3'd4
    } state_t;

    // Terminal counts, sized to the registers they are compared against.
    localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] STAGGER_LAST = 16'(STAGGER_CYCLES - 1);
    localparam logic [3:0]  LF_LAST      = 4'(LOSS_FILTER - 1);

    // Loss counter holds at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // ------------------------------------------------------------------
    // pll_lock synchronizer; r_sync is the only sampler of pll_lock.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_lock_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.pll_lock};
        end
    end

    assign w_lock_s = r_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Sequencer registers
    // ------------------------------------------------------------------
    state_t      r_state;
    logic [15:0] r_cnt;          // settle / stagger dwell counter
    logic [3:0]  r_lf;           // consecutive synchronized-low cycles
    logic [7:0]  r_loss_cnt;
    logic        r_core_rst_n;
    logic        r_periph_rst_n;
    logic        r_ready;

    state_t      w_nxt;
    logic [15:0] w_cnt_nxt;
    logic [3:0]  w_lf_nxt;
    logic        w_lf_hit;

    // A loss qualifies on the cycle that would bring the run of lows up to
    // LOSS_FILTER, so LOST is entered on that same edge.
    assign w_lf_hit = !w_lock_s && (r_lf == LF_LAST);

    // ------------------------------------------------------------------
    // Next-state decode
    // ------------------------------------------------------------------
    always_comb begin
        w_nxt     = r_state;
        w_cnt_nxt = r_cnt;
        w_lf_nxt  = '0;

        case (r_state)
            WAIT_LOCK: begin
                w_cnt_nxt = '0;
                if (w_lock_s) begin
                    w_nxt = SETTLE;
                end
            end

            SETTLE: begin
                if (!w_lock_s) begin
                    w_nxt     = WAIT_LOCK;
                    w_cnt_nxt = '0;
                end else if (r_cnt == SETTLE_LAST) begin
                    w_nxt     = CORE_UP;
                    w_cnt_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end

            CORE_UP, RUN: begin
                w_lf_nxt = w_lock_s ? 4'd0 : r_lf + 4'd1;
                // Loss outranks the software request, which outranks the
                // stagger completion.
                if (w_lf_hit) begin
                    w_nxt     = LOST;
                    w_cnt_nxt = '0;
                    w_lf_nxt  = '0;
                end else if (bus.sw_reset_req) begin
                    w_nxt     = WAIT_LOCK;
                    w_cnt_nxt = '0;
                    w_lf_nxt  = '0;
                end else if (r_state == CORE_UP) begin
                    if (r_cnt == STAGGER_LAST) begin
                        w_nxt     = RUN;
                        w_cnt_nxt = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 16'd1;
                    end
                end
            end

            LOST: begin
                w_nxt     = WAIT_LOCK;
                w_cnt_nxt = '0;
            end

            default: begin
                w_nxt     = WAIT_LOCK;
                w_cnt_nxt = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and outputs, all loaded from the next-state decode so every
    // output moves on the same edge as state.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= WAIT_LOCK;
            r_cnt          <= '0;
            r_lf           <= '0;
            r_loss_cnt     <= '0;
            r_core_rst_n   <= 1'b0;
            r_periph_rst_n <= 1'b0;
            r_ready        <= 1'b0;
        end else begin
            r_state        <= w_nxt;
            r_cnt          <= w_cnt_nxt;
            r_lf           <= w_lf_nxt;
            if (w_nxt == LOST) begin
                r_loss_cnt <= sat_inc8(r_loss_cnt);
            end
            r_core_rst_n   <= (w_nxt == CORE_UP) || (w_nxt == RUN);
            r_periph_rst_n <= (w_nxt == RUN);
            r_ready        <= (w_nxt == RUN);
        end
    end

    assign bus.state         = r_state;
    assign bus.core_rst_n    = r_core_rst_n;
    assign bus.periph_rst_n  = r_periph_rst_n;
    assign bus.ready         = r_ready;
    assign bus.lock_loss_cnt = r_loss_cnt;

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// ----------------------------------------------------------------------------
// tb_pll_lock_reset_seq
//   Bench for pll_lock_reset_seq with SYNC_STAGES=2, SETTLE_CYCLES=8,
//   STAGGER_CYCLES=4, LOSS_FILTER=3. Each clock edge the stimulus side runs
//   a timeline reference model (phase plus entry timestamp, LOCK history)
//   and queues the expected outputs; a monitor pops and compares them on
//   the falling edge. Directed checks cover the edge numbers and counts
//   that the sequence is expected to produce.
// ----------------------------------------------------------------------------
module tb_pll_lock_reset_seq;

    localparam int SYNC    = 2;
    localparam int SETTLE  = 8;
    localparam int STAGGER = 4;
    localparam int LF      = 3;

    logic clk;
    logic rst_n;

    pll_lock_reset_seq_if bus ();

    pll_lock_reset_seq #(
        .SYNC_STAGES   (SYNC),
        .SETTLE_CYCLES (SETTLE),
        .STAGGER_CYCLES(STAGGER),
        .LOSS_FILTER   (LF)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int         edge_n;
        logic [13:0] v;      // {state, core_rst_n, periph_rst_n, ready, lock_loss_cnt}
    } exp_t;

    exp_t exp_q[$];
    bit   hist[$];           // pll_lock as sampled at edge k is hist[k-1]
    int   m_edge;
    int   m_phase;           // 0 wait, 1 settle, 2 core up, 3 run, 4 lost
    int   m_enter;           // edge at which the current phase began
    int   m_cnt;

    function automatic bit lock_s_at(int k);
        if (k <= SYNC) return 1'b0;
        return hist[k - 1 - SYNC];
    endfunction

    // Loss qualifies when the last LF synchronized samples are all low.
    function automatic bit loss_at(int k);
        for (int j = 0; j < LF; j++) begin
            if (lock_s_at(k - j)) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        hist.delete();
        m_edge  = 0;
        m_phase = 0;
        m_enter = 0;
        m_cnt   = 0;
    endtask

    task automatic go(input int p);
        m_phase = p;
        m_enter = m_edge;
    endtask

    task automatic model_edge(input bit lock, input bit sw);
        bit   ls;
        int   dwell;
        exp_t e;
        m_edge++;
        hist.push_back(lock);
        ls    = lock_s_at(m_edge);
        dwell = m_edge - m_enter;
        case (m_phase)
            0: if (ls) go(1);
            1: begin
                if (!ls) go(0);
                else if (dwell == SETTLE) go(2);
            end
            2, 3: begin
                if (loss_at(m_edge)) begin
                    go(4);
                    if (m_cnt < 255) m_cnt++;
                end else if (sw) begin
                    go(0);
                end else if (m_phase == 2 && dwell == STAGGER) begin
                    go(3);
                end
            end
            default: go(0);
        endcase
        e.edge_n = m_edge;
        e.v = {3'(m_phase), (m_phase == 2 || m_phase == 3), (m_phase == 3),
               (m_phase == 3), 8'(m_cnt)};
        exp_q.push_back(e);
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk($sformatf("edge%0d_outputs", e.edge_n),
                    32'({bus.state, bus.core_rst_n, bus.periph_rst_n, bus.ready, bus.lock_loss_cnt}),
                    32'(e.v));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input bit lock, input bit sw);
        bus.pll_lock     = lock;
        bus.sw_reset_req = sw;
        @(posedge clk);
        model_edge(lock, sw);
        #1;
    endtask

    task automatic do_reset(input string tag);
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        chk({tag, "_state"},  32'(bus.state), 32'd0);
        chk({tag, "_core"},   32'(bus.core_rst_n), 32'd0);
        chk({tag, "_periph"}, 32'(bus.periph_rst_n), 32'd0);
        chk({tag, "_ready"},  32'(bus.ready), 32'd0);
        chk({tag, "_cnt"},    32'(bus.lock_loss_cnt), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int core_rise;
        int periph_rise;
        int ready_rise;
        int settle_edge;
        int lost_idx;
        int cycles;
        bit lvl;
        int len;

        bus.pll_lock     = 1'b0;
        bus.sw_reset_req = 1'b0;
        rst_n            = 1'b1;
        model_reset();
        #1;

        // Settle abort: LOCK drops while the settle count is at 5.
        do_reset("por");
        repeat (6) step(1'b1, 1'b0);
        repeat (2) step(1'b0, 1'b0);
        core_rise = -1;
        for (int i = 9; i <= 22; i++) begin
            step(1'b1, 1'b0);
            if (i == 9) chk("abort_state", 32'(bus.state), 32'd0);
            if (core_rise < 0 && bus.core_rst_n === 1'b1) core_rise = m_edge;
        end
        chk("abort_core_rise_edge", 32'(core_rise), 32'd19);
        chk("abort_loss_cnt", 32'(bus.lock_loss_cnt), 32'd0);

        // Power-up with LOCK already high.
        bus.pll_lock = 1'b1;
        do_reset("rst2");
        settle_edge = -1; core_rise = -1; periph_rise = -1; ready_rise = -1;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0);
            if (settle_edge < 0 && bus.state === 3'd1) settle_edge = m_edge;
            if (core_rise < 0 && bus.core_rst_n === 1'b1) core_rise = m_edge;
            if (periph_rise < 0 && bus.periph_rst_n === 1'b1) periph_rise = m_edge;
            if (ready_rise < 0 && bus.ready === 1'b1) ready_rise = m_edge;
        end
        chk("pwrup_settle_edge", 32'(settle_edge), 32'd3);
        chk("pwrup_core_edge",   32'(core_rise),   32'd11);
        chk("pwrup_periph_edge", 32'(periph_rise), 32'd15);
        chk("pwrup_ready_edge",  32'(ready_rise),  32'd15);

        // Two-cycle glitch is filtered.
        repeat (2) step(1'b0, 1'b0);
        repeat (8) step(1'b1, 1'b0);
        chk("glitch_state",  32'(bus.state), 32'd3);
        chk("glitch_periph", 32'(bus.periph_rst_n), 32'd1);

        // Real loss: LOST two edges after the third low sample.
        lost_idx = -1;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0);
            if (i == 3) chk("loss_pre_resets", 32'({bus.core_rst_n, bus.periph_rst_n}), 32'd3);
            if (lost_idx < 0 && bus.state === 3'd4) begin
                lost_idx = i;
                chk("loss_resets_fall", 32'({bus.core_rst_n, bus.periph_rst_n}), 32'd0);
            end
        end
        chk("loss_edge_offset", 32'(lost_idx), 32'd4);
        chk("loss_cnt1", 32'(bus.lock_loss_cnt), 32'd1);
        repeat (16) step(1'b1, 1'b0);
        chk("relock_run", 32'(bus.state), 32'd3);

        // Loss and software request on the same edge: loss wins.
        for (int i = 0; i < 5; i++) step(1'b0, i == 4);
        chk("simul_state", 32'(bus.state), 32'd4);
        chk("simul_cnt",   32'(bus.lock_loss_cnt), 32'd2);
        repeat (16) step(1'b1, 1'b0);

        // Software request alone.
        step(1'b1, 1'b1);
        chk("sw_state", 32'(bus.state), 32'd0);
        chk("sw_cnt",   32'(bus.lock_loss_cnt), 32'd2);
        repeat (4) step(1'b1, 1'b0);

        // Randomized LOCK runs with sparse software requests.
        cycles = 0;
        while (cycles < 3000) begin
            lvl = 1'($urandom_range(0, 1));
            len = lvl ? int'($urandom_range(1, 24)) : int'($urandom_range(1, 5));
            for (int i = 0; i < len; i++) begin
                step(lvl, $urandom_range(0, 31) == 0);
                cycles++;
            end
        end

        // Saturation of the loss counter.
        do_reset("rst3");
        for (int n = 0; n < 260; n++) begin
            repeat (14) step(1'b1, 1'b0);
            repeat (6)  step(1'b0, 1'b0);
        end
        chk("sat_cnt", 32'(bus.lock_loss_cnt), 32'd255);

        // Asynchronous reset in CORE_UP.
        repeat (12) step(1'b1, 1'b0);
        chk("pre_async_state", 32'(bus.state), 32'd2);
        do_reset("async");
        repeat (4) step(1'b0, 1'b0);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
